// File: rtl/escalonador_processos_if.sv
// Command and selection bus between the process scheduler and its clients
// (process creation, context save, halt detection and program counter).
interface escalonador_processos_if;
    logic        criarProc;
    logic [4:0]  indiceCriar;
    logic [15:0] PCInicial;
    logic        salvarContexto;
    logic [4:0]  indiceSalvar;
    logic [15:0] PCSalvo;
    logic        finalizarProc;
    logic [4:0]  indiceFinalizar;
    logic        escalonar;
    logic [4:0]  indiceProxProc;
    logic [15:0] PCProxProc;
    logic        proxValido;
    logic        ocupado;
    logic [4:0]  numProcAtivos;

    modport master (
        output criarProc, indiceCriar, PCInicial,
        output salvarContexto, indiceSalvar, PCSalvo,
        output finalizarProc, indiceFinalizar, escalonar,
        input  indiceProxProc, PCProxProc, proxValido, ocupado, numProcAtivos
    );

    modport slave (
        input  criarProc, indiceCriar, PCInicial,
        input  salvarContexto, indiceSalvar, PCSalvo,
        input  finalizarProc, indiceFinalizar, escalonar,
        output indiceProxProc, PCProxProc, proxValido, ocupado, numProcAtivos
    );
endinterface

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: process table (valid bit + saved PC per slot)
// and a one-slot-per-cycle search FSM that picks the next valid process after the last one.
module escalonador_processos #(
    parameter int unsigned NUM_PROC = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    escalonador_processos_if.slave  bus
);

    typedef enum logic [1:0] {OCIOSO, BUSCA, PRONTO} estado_t;

    localparam logic [4:0] ULTIMO_SLOT = 5'(NUM_PROC - 1);
    localparam logic [4:0] MAX_EXAM    = 5'(NUM_PROC - 2);

    logic [NUM_PROC-1:1] valido;
    logic [15:0]         pc [1:NUM_PROC-1];

    estado_t     estado;
    logic [4:0]  ponteiro;
    logic [4:0]  ultimo;
    logic [4:0]  examinados;
    logic [4:0]  indice_q;
    logic [15:0] pc_q;
    logic        valido_q;
    logic        ocupado_q;

    logic        sel_valido;
    logic [15:0] sel_pc;
    logic [4:0]  ativos;

    // Slot 0 belongs to the OS and is skipped when wrapping.
    function automatic logic [4:0] proximo(input logic [4:0] p);
        return (p >= ULTIMO_SLOT) ? 5'd1 : p + 5'd1;
    endfunction

    // Same-slot priority: finalizar > salvar > criar. A save to an empty slot
    // has no effect, so a create in that cycle still takes place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valido <= '0;
            for (int unsigned i = 1; i < NUM_PROC; i++) begin
                pc[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_PROC; i++) begin
                if (bus.finalizarProc && bus.indiceFinalizar == 5'(i)) begin
                    valido[i] <= 1'b0;
                end else if (bus.salvarContexto && bus.indiceSalvar == 5'(i) && valido[i]) begin
                    pc[i] <= bus.PCSalvo;
                end else if (bus.criarProc && bus.indiceCriar == 5'(i)) begin
                    valido[i] <= 1'b1;
                    pc[i]     <= bus.PCInicial;
                end
            end
        end
    end

    always_comb begin
        sel_valido = 1'b0;
        sel_pc     = '0;
        ativos     = '0;
        for (int unsigned i = 1; i < NUM_PROC; i++) begin
            if (ponteiro == 5'(i)) begin
                sel_valido = valido[i];
                sel_pc     = pc[i];
            end
            ativos = ativos + 5'(valido[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= OCIOSO;
            ponteiro   <= '0;
            ultimo     <= '0;
            examinados <= '0;
            indice_q   <= '0;
            pc_q       <= '0;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.escalonar) begin
                        estado     <= BUSCA;
                        ponteiro   <= proximo(ultimo);
                        examinados <= '0;
                        valido_q   <= 1'b0;
                        ocupado_q  <= 1'b1;
                    end
                end
                BUSCA: begin
                    if (sel_valido) begin
                        estado    <= PRONTO;
                        indice_q  <= ponteiro;
                        pc_q      <= sel_pc;
                        ultimo    <= ponteiro;
                        valido_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                    end else if (examinados == MAX_EXAM) begin
                        estado    <= OCIOSO;
                        indice_q  <= '0;
                        pc_q      <= '0;
                        valido_q  <= 1'b0;
                        ocupado_q <= 1'b0;
                    end else begin
                        ponteiro   <= proximo(ponteiro);
                        examinados <= examinados + 5'd1;
                    end
                end
                PRONTO: begin
                    if (bus.escalonar) begin
                        estado     <= BUSCA;
                        ponteiro   <= proximo(ultimo);
                        examinados <= '0;
                        valido_q   <= 1'b0;
                        ocupado_q  <= 1'b1;
                    end else if (bus.finalizarProc && bus.indiceFinalizar == indice_q) begin
                        estado   <= OCIOSO;
                        valido_q <= 1'b0;
                    end else if (bus.salvarContexto && bus.indiceSalvar == indice_q) begin
                        pc_q <= bus.PCSalvo;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.indiceProxProc = indice_q;
    assign bus.PCProxProc     = pc_q;
    assign bus.proxValido     = valido_q;
    assign bus.ocupado        = ocupado_q;
    assign bus.numProcAtivos  = ativos;

endmodule

// File: doc/escalonador_processos.md
ESCALONADOR_PROCESSOS -- requirements
Module: escalonador_processos

Interface
REQ-001 Parameter NUM_PROC, default 8, number of process-table slots including slot 0 (OS/BIOS); legal range 2..32.
REQ-002 clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 criarProc  in  1  single-cycle pulse: register a new process.
REQ-005 indiceCriar  in  5  slot index for criarProc.
REQ-006 PCInicial  in  16  start PC for criarProc.
REQ-007 salvarContexto  in  1  single-cycle pulse: store preempted process PC (quantum expiry).
REQ-008 indiceSalvar  in  5  slot index for salvarContexto.
REQ-009 PCSalvo  in  16  PC to store (program counter's proximoPC).
REQ-010 finalizarProc  in  1  single-cycle pulse: process reached halt; free slot.
REQ-011 indiceFinalizar  in  5  slot index for finalizarProc.
REQ-012 escalonar  in  1  single-cycle pulse: request selection of next process.
REQ-013 indiceProxProc  out  5  selected slot index, to program counter.
REQ-014 PCProxProc  out  16  saved PC of selected slot, to program counter.
REQ-015 proxValido  out  1  1 = selection outputs valid.
REQ-016 ocupado  out  1  1 = search in progress.
REQ-017 numProcAtivos  out  5  count of valid slots 1..NUM_PROC-1.

Function
REQ-018 Table: per slot 1..NUM_PROC-1 a valid bit and 16-bit PC; slot 0 never stored; commands addressing index 0 or index >= NUM_PROC are ignored.
REQ-019 criarProc: valid=1, PC=PCInicial at the next edge; creating an already valid slot overwrites PC, count unchanged.
REQ-020 salvarContexto: PC=PCSalvo at the next edge only if slot valid; valid bit unchanged.
REQ-021 finalizarProc: valid=0 at the next edge; PC content don't-care.
REQ-022 Simultaneous commands on different slots all take effect in the same cycle; on the same slot priority is finalizarProc > salvarContexto > criarProc.
REQ-023 numProcAtivos reflects the table one cycle after any command; never exceeds NUM_PROC-1, never underflows.
REQ-024 FSM states: OCIOSO, BUSCA, PRONTO.
REQ-025 OCIOSO: escalonar=1 -> BUSCA, ocupado=1 next cycle, proxValido=0, scan pointer = ultimo+1 (wrap NUM_PROC-1 -> 1, skip 0); ultimo resets to 0 so the first scan starts at slot 1.
REQ-026 BUSCA: examines one slot per cycle using current table contents (including writes completed in prior cycles).
REQ-027 BUSCA, examined slot valid -> PRONTO: indiceProxProc=slot, PCProxProc=slot PC, ultimo=slot, proxValido=1, ocupado=0.
REQ-028 BUSCA, NUM_PROC-1 slots examined with none valid -> OCIOSO: indiceProxProc=0, PCProxProc=0, proxValido=0, ocupado=0, ultimo unchanged.
REQ-029 Latency: selection found at the k-th examined slot -> proxValido=1 exactly k+1 cycles after the escalonar edge.
REQ-030 PRONTO: outputs held stable; escalonar=1 starts a new BUSCA from ultimo+1; finalizarProc on the selected slot clears proxValido next cycle and returns to OCIOSO; salvarContexto on the selected slot updates PCProxProc next cycle.
REQ-031 escalonar while ocupado=1 is ignored.
REQ-032 Single valid process: each escalonar reselects it after a full wrap (k = NUM_PROC-1).

Reset
REQ-033 reset=0: all valid bits 0, all PCs 0, ultimo=0, FSM OCIOSO, indiceProxProc=0, PCProxProc=0, proxValido=0, ocupado=0, numProcAtivos=0, asynchronously.
REQ-034 reset asserted mid-BUSCA or in PRONTO aborts the operation; first escalonar after release scans from slot 1.

Verification
REQ-035 Create slots 2 (PC 0x0040) and 5 (PC 0x0100), escalonar -> proxValido=1 after 3 cycles, index 2, PC 0x0040; escalonar again -> index 5, PC 0x0100 after 4 cycles.
REQ-036 Index 5 selected, salvarContexto(5, 0x0123), then escalonar twice -> index 2, then index 5 with PC 0x0123; numProcAtivos=2 throughout.
REQ-037 Empty table, escalonar -> ocupado=1 for 7 cycles (NUM_PROC=8), then index 0, PC 0, proxValido=0.
REQ-038 Same cycle finalizarProc(3), salvarContexto(3, 0x0ABC), criarProc(3, 0x0010) on slot 3 previously valid -> slot 3 invalid, numProcAtivos decremented by 1.
REQ-039 reset=0 asserted during BUSCA with 4 valid slots -> all outputs 0 immediately; after release, escalonar with empty table -> proxValido=0 after 7 cycles.
REQ-040 escalonar pulsed during BUSCA and criarProc(0, 0x0200) -> both ignored; search completes with original latency, numProcAtivos unchanged.
